trax_move_tx: RTL and testbench

TRAX_MOVE_TX -- requirements
Module: trax_move_tx

---
 rtl/trax_move_tx.sv | 209 ++++++++++++++++++++
 tb/tb_trax_move_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/trax_move_tx.sv
// Trax move serializer: renders a 22-bit move word as ASCII ("A1+\n") and sends it 8N1 over a UART line.
// Latency: start bit on tx the cycle after an accepted start; back-to-back bytes, done pulses as busy falls.
// Backpressure: start is sampled only while idle and ignored while busy; define TRAX_TX_PARITY_EN for 8E1 framing.
module trax_move_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [21:0] move,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        tx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
`ifdef TRAX_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] clk_cnt;
   logic [2:0]  bit_idx;
   logic [2:0]  bytes_left;
   logic [39:0] char_buf;
   logic [7:0]  shift_reg;
   logic        bit_end;
`ifdef TRAX_TX_PARITY_EN
   logic        parity_bit;
`endif

   // move word fields and encoder results
   logic [1:0]  tile;
   logic [9:0]  col;
   logic [9:0]  row;
   logic        encodable;
   logic [6:0]  row1;
   logic [3:0]  tens;
   logic [6:0]  tens_x10;
   logic [6:0]  ones;
   logic [7:0]  tile_chr;
   logic [39:0] enc_buf;
   logic [2:0]  enc_last;

   assign tile      = move[21:20];
   assign col       = move[19:10];
   assign row       = move[9:0];
   assign encodable = (tile != 2'b00) && (col <= 10'd25) && (row <= 10'd98);
   assign row1      = row[6:0] + 7'd1;
   assign tens_x10  = {tens, 3'b000} + {2'b00, tens, 1'b0};
   assign ones      = row1 - tens_x10;
   assign bit_end   = (clk_cnt == BIT_LAST);

   // Tens digit by threshold compare so no divider is needed
   always_comb begin
      tens = 4'd0;
      if      (row1 >= 7'd90) tens = 4'd9;
      else if (row1 >= 7'd80) tens = 4'd8;
      else if (row1 >= 7'd70) tens = 4'd7;
      else if (row1 >= 7'd60) tens = 4'd6;
      else if (row1 >= 7'd50) tens = 4'd5;
      else if (row1 >= 7'd40) tens = 4'd4;
      else if (row1 >= 7'd30) tens = 4'd3;
      else if (row1 >= 7'd20) tens = 4'd2;
      else if (row1 >= 7'd10) tens = 4'd1;
   end

   // Assemble the character string, first byte in the low lane
   always_comb begin
      case (tile)
         2'b01:   tile_chr = 8'h2B;
         2'b10:   tile_chr = 8'h2F;
         default: tile_chr = 8'h5C;
      endcase
      if (tens == 4'd0) begin
         enc_buf  = {8'h00, 8'h0A, tile_chr, 8'h30 + {1'b0, ones}, 8'h41 + {3'b000, col[4:0]}};
         enc_last = 3'd3;
      end else begin
         enc_buf  = {8'h0A, tile_chr, 8'h30 + {1'b0, ones}, 8'h30 + {4'h0, tens},
                     8'h41 + {3'b000, col[4:0]}};
         enc_last = 3'd4;
      end
   end

   // State register; reset wins over everything, including start
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start && encodable) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_START;
         S_START: if (bit_end) state_nxt = S_DATA;
         S_DATA: begin
            if (bit_end && bit_idx == 3'd7) begin
`ifdef TRAX_TX_PARITY_EN
               state_nxt = S_PARITY;
`else
               state_nxt = S_STOP;
`endif
            end
         end
`ifdef TRAX_TX_PARITY_EN
         S_PARITY: if (bit_end) state_nxt = S_STOP;
`endif
         S_STOP:  if (bit_end) state_nxt = (bytes_left == 3'd0) ? S_IDLE : S_LOAD;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: latch string, bit timing, shifting, byte stepping, status pulses.
   // LOAD is the first cycle of the start bit, so the bit counter resumes at 1
   // and each byte costs exactly its bit times with no idle gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_cnt    <= 16'd0;
         bit_idx    <= 3'd0;
         bytes_left <= 3'd0;
         char_buf   <= 40'd0;
         shift_reg  <= 8'd0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef TRAX_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               clk_cnt <= 16'd0;
               if (start) begin
                  if (encodable) begin
                     char_buf   <= enc_buf;
                     bytes_left <= enc_last;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               shift_reg <= char_buf[7:0];
               clk_cnt   <= 16'd1;
               bit_idx   <= 3'd0;
`ifdef TRAX_TX_PARITY_EN
               parity_bit <= ^char_buf[7:0];
`endif
            end
            S_DATA: begin
               if (bit_end) begin
                  clk_cnt <= 16'd0;
                  if (bit_idx != 3'd7) begin
                     bit_idx   <= bit_idx + 3'd1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  clk_cnt <= 16'd0;
                  if (bytes_left == 3'd0) begin
                     done <= 1'b1;
                  end else begin
                     bytes_left <= bytes_left - 3'd1;
                     char_buf   <= {8'h00, char_buf[39:8]};
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: begin
               clk_cnt <= bit_end ? 16'd0 : clk_cnt + 16'd1;
            end
         endcase
      end
   end

   // Line driver: idle/stop high, start low, data LSB first
   always_comb begin
      tx = 1'b1;
      case (state)
         S_LOAD, S_START: tx = 1'b0;
         S_DATA:          tx = shift_reg[0];
`ifdef TRAX_TX_PARITY_EN
         S_PARITY:        tx = parity_bit;
`endif
         default:         tx = 1'b1;
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_trax_move_tx.sv
// Directed bench for trax_move_tx with CLKS_PER_BIT=4: reset state, string encoding,
// unencodable moves, start while busy, and reset mid-frame.
// tx is sampled on the falling edge at the centre of every bit time.
module tb_trax_move_tx;

   localparam int CPB = 4;
`ifdef TRAX_TX_PARITY_EN
   localparam int BPB = 11;
`else
   localparam int BPB = 10;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [21:0] move;
   logic        start;
   logic        busy;
   logic        done;
   logic        err;
   logic        tx;

   int total = 0;
   int bad   = 0;

   trax_move_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .move  (move),
      .start (start),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   function automatic logic [21:0] mk(input logic [1:0] t, input int c, input int r);
      return {t, 10'(c), 10'(r)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one start, log tx for the whole frame, then decode and check it.
   // re_at >= 0 re-asserts start with re_mv at that cycle of the frame.
   task automatic run_frame(input string tag, input logic [21:0] mv, input int n,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input logic [7:0] e4,
                            input int re_at, input logic [21:0] re_mv);
      logic [7:0] exp_b [5];
      logic       tx_log [256];
      int         ns, busy_n, done_n, done_at, frame_len;
      logic [7:0] rx;
      logic       framing_ok;
      exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3; exp_b[4] = e4;
      frame_len = n * BPB * CPB;
      ns = frame_len + 6;
      busy_n = 0; done_n = 0; done_at = -1;
      @(negedge clk);
      move  = mv;
      start = 1'b1;
      for (int s = 0; s < ns; s++) begin
         @(negedge clk);
         tx_log[s] = tx;
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at < 0) done_at = s;
         end
         start = (s == re_at);
         if (s == re_at) move = re_mv;
      end
      start = 1'b0;
      chk({tag, " latency"}, 32'(tx_log[1]), 32'd0);
      chk({tag, " busy_cycles"}, 32'(busy_n), 32'(frame_len));
      chk({tag, " done_count"}, 32'(done_n), 32'd1);
      chk({tag, " done_cycle"}, 32'(done_at), 32'(frame_len));
      chk({tag, " idle_after"}, 32'(tx_log[ns-1]), 32'd1);
      for (int b = 0; b < n; b++) begin
         rx = 8'h00;
         for (int j = 1; j <= 8; j++)
            rx[j-1] = tx_log[(b*BPB + j)*CPB + CPB/2];
         framing_ok = (tx_log[(b*BPB)*CPB + CPB/2] == 1'b0) &&
                      (tx_log[(b*BPB + BPB-1)*CPB + CPB/2] == 1'b1);
`ifdef TRAX_TX_PARITY_EN
         framing_ok = framing_ok && (tx_log[(b*BPB + 9)*CPB + CPB/2] == ^exp_b[b]);
`endif
         chk($sformatf("%s byte%0d", tag, b), 32'(rx), 32'(exp_b[b]));
         chk($sformatf("%s frame%0d", tag, b), 32'(framing_ok), 32'd1);
      end
   endtask

   // Unencodable move: err pulses once, line and busy never move
   task automatic run_bad(input string tag, input logic [21:0] mv);
      int err_n, busy_n, low_n;
      err_n = 0; busy_n = 0; low_n = 0;
      @(negedge clk);
      move  = mv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " err_next"}, 32'(err), 32'd1);
      for (int s = 0; s < 8; s++) begin
         if (err) err_n++;
         if (busy) busy_n++;
         if (!tx) low_n++;
         @(negedge clk);
      end
      chk({tag, " err_pulses"}, 32'(err_n), 32'd1);
      chk({tag, " quiet"}, 32'(busy_n + low_n), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      move  = '0;
      repeat (3) @(negedge clk);
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // "A1+\n"
      run_frame("a1", mk(2'b01, 0, 0), 4, 8'h41, 8'h31, 8'h2B, 8'h0A, 8'h00, -1, '0);
      // "C12/\n"
      run_frame("c12", mk(2'b10, 2, 11), 5, 8'h43, 8'h31, 8'h32, 8'h2F, 8'h0A, -1, '0);
      // "Z99\\\n"
      run_frame("z99", mk(2'b11, 25, 98), 5, 8'h5A, 8'h39, 8'h39, 8'h5C, 8'h0A, -1, '0);
      // "B10+\n": row 9 is the first two-digit row
      run_frame("b10", mk(2'b01, 1, 9), 5, 8'h42, 8'h31, 8'h30, 8'h2B, 8'h0A, -1, '0);
      // start during a frame with another move is ignored
      run_frame("ignore", mk(2'b01, 0, 0), 4, 8'h41, 8'h31, 8'h2B, 8'h0A, 8'h00,
                20, mk(2'b11, 25, 98));

      run_bad("tile0", mk(2'b00, 3, 3));
      run_bad("col26", mk(2'b01, 26, 0));
      run_bad("row99", mk(2'b01, 0, 99));

      // Reset during data bits of byte 2, then a clean frame
      @(negedge clk);
      move  = mk(2'b10, 2, 11);
      start = 1'b1;
      for (int s = 0; s < 2*BPB*CPB + 3*CPB; s++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("midrst busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst tx", 32'(tx), 32'd1);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      @(negedge clk);
      chk("midrst stays_idle", 32'(busy), 32'd0);
      run_frame("after_rst", mk(2'b10, 2, 11), 5, 8'h43, 8'h31, 8'h32, 8'h2F, 8'h0A, -1, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
